id_ex_stage_reg: RTL and testbench
==================================

Name: id_ex_stage_reg

Overview:
- ID/EX pipeline register with integrated load-use hazard detection and registered forwarding-select generation.
- Sits between the decode stage and the EX-stage operand forwarding muxes.
- Captures decoded operands and controls each cycle, and inserts bubbles on load-use hazards or branch flush.
- Precomputes the 2-bit forward selects for operands A and B one cycle early, so they arrive aligned with the operand data.

Parameters:
DATA_W, 32, operand/PC/immediate width
RADDR_W, 5, register-address width
ALUOP_W, 4, ALU operation code width

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
id_valid  in  1  ID holds a real instruction
id_pc  in  DATA_W  PC of ID instruction
id_rs_data  in  DATA_W  register-file read A
id_rt_data  in  DATA_W  register-file read B
id_imm  in  DATA_W  sign-extended immediate
id_rs  in  RADDR_W  source A address
id_rt  in  RADDR_W  source B address
id_rd  in  RADDR_W  destination address (already RegDst-resolved)
id_ctrl  in  ALUOP_W+5  {RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, ALUOp}
exmem_regwrite  in  1  RegWrite of the current EX/MEM register
exmem_rd  in  RADDR_W  rd of the current EX/MEM register
hold  in  1  global pipeline freeze (memory busy)
flush  in  1  branch taken, squash the ID instruction
ex_valid  out  1  registered valid
ex_pc, ex_rs_data, ex_rt_data, ex_imm  out  DATA_W each  registered operands
ex_rs, ex_rt, ex_rd  out  RADDR_W each  registered addresses
ex_ctrl  out  ALUOP_W+5  registered controls
ex_fwd_a, ex_fwd_b  out  2 each  forward selects: 00 regfile, 10 EX/MEM ALU result, 01 MEM/WB write data
stall_if_id  out  1  combinational; freeze PC and IF/ID this cycle

Behaviour:
- Reset:
  - All ex_* outputs are 0; ex_fwd_a and ex_fwd_b are 2'b00; ex_valid is 0.
  - An all-zero ex_ctrl is a legal bubble.
- Load-use detection (combinational, from current register contents):
  - luse = ex_valid & ex_ctrl.MemRead & ex_rd!=0 & id_valid & (ex_rd==id_rs | (ex_rd==id_rt & id_reads_rt)).
  - id_reads_rt = !ALUSrc | MemWrite.
  - stall_if_id = luse & !flush & !hold.
- Update priority on each rising edge: reset > flush > hold > luse > load.
  - flush: write a bubble (ex_valid=0, ex_ctrl=0, ex_fwd_*=00). Data fields are don't-care and are zeroed.
  - hold: all registers keep their value, stall_if_id=0 (the global hold already freezes upstream).
  - luse: write a bubble; ID is re-presented next cycle.
  - Otherwise capture all id_* fields; ex_valid=id_valid.
- Forward select for source A, computed on the ID-side values and registered with the load:
  - 10 if ex_valid & ex_ctrl.RegWrite & ex_rd!=0 & ex_rd==id_rs. The current EX instruction becomes EX/MEM next cycle.
  - else 01 if exmem_regwrite & exmem_rd!=0 & exmem_rd==id_rs. EX/MEM becomes MEM/WB next cycle.
  - else 00.
  - Source B is identical using id_rt.
  - EX-side priority over MEM-side gives youngest-producer-wins.
- Exactly one bubble per load-use.
  - The cycle after the bubble, the load sits in EX/MEM, so the dependent instruction loads with fwd=01 and takes MEM/WB write data.
- Register $0 never forwards; selects are 00 for rs=0.
- flush and luse in the same cycle: flush wins and stall_if_id=0.
- Reset mid-stall: the next state is the reset state and stall_if_id drops once reset is sampled.
- Latency is one cycle from ID capture to the EX outputs. No combinational path from id_* to ex_*.

Decomposition:
- Shared pipeline package holds:
  - control-bundle field offsets (CTRL_REGWRITE, CTRL_MEMREAD, CTRL_MEMWRITE, CTRL_MEMTOREG, CTRL_ALUSRC, ALUOP slice);
  - forward-select constants FWD_REG=2'b00, FWD_EXMEM=2'b10, FWD_MEMWB=2'b01;
  - BUBBLE_CTRL=0.
- One natural sub-module: fwd_sel_calc. It is a pure-combinational priority comparator, instantiated twice (A and B) and reused by any future branch-in-ID forwarding.

Test Plan:
- Reset then idle: hold reset 2 cycles -> all outputs 0, ex_fwd_a/b=00, stall_if_id=0.
- EX-to-EX forward:
  - Stimulus: add r3 (RegWrite, rd=3) loaded, then ID sub with rs=3, rt=4, exmem_regwrite=0.
  - Required: next cycle ex_fwd_a=10, ex_fwd_b=00.
- Double hazard:
  - Stimulus: EX rd=5 RegWrite, exmem_rd=5 exmem_regwrite=1, ID rs=5, rt=5.
  - Required: ex_fwd_a=10, ex_fwd_b=10 (youngest wins).
- Load-use:
  - Stimulus: lw r7 in EX (MemRead, rd=7), ID rs=7.
  - Required: stall_if_id=1 for exactly one cycle, a bubble is loaded (ex_valid=0, ex_ctrl=0).
  - Following cycle, with exmem_rd=7 and exmem_regwrite=1: instruction loaded with ex_fwd_a=01.
- Flush vs luse: set flush=1 during a load-use condition -> bubble loaded, stall_if_id=0, no second bubble.
- Hold plus $0:
  - Stimulus: hold=1 for 3 cycles with changing id_*.
  - Required: outputs unchanged.
  - Then EX rd=0 RegWrite with ID rs=0: ex_fwd_a=00.

Source files
------------

// File: rtl/id_ex_stage_reg_pkg.sv
// Shared pipeline definitions for the ID/EX stage register and its helpers.
// The control bundle is packed as {RegWrite, MemRead, MemWrite, MemtoReg,
// ALUSrc, ALUOp}. ALUOp occupies the low ALUOP_W bits. The single-bit
// controls sit directly above it, at the offsets given below.
package id_ex_stage_reg_pkg;

  // Bit offsets of the single-bit controls, counted from the top of the
  // ALUOp field. The absolute bit index is ALUOP_W + CTRL_xxx.
  localparam int CTRL_ALUSRC   = 0;
  localparam int CTRL_MEMTOREG = 1;
  localparam int CTRL_MEMWRITE = 2;
  localparam int CTRL_MEMREAD  = 3;
  localparam int CTRL_REGWRITE = 4;
  localparam int CTRL_NBITS    = 5;

  // The ALUOp slice starts at bit 0 of the control bundle.
  localparam int ALUOP_LSB = 0;

  // Operand forwarding selects that feed the EX-stage muxes.
  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

  // An all-zero control bundle is a harmless bubble: no write, no memory access.
  localparam logic BUBBLE_CTRL = 1'b0;

  // Absolute bit index of a single-bit control within a bundle whose
  // ALUOp field is aluop_w bits wide.
  function automatic int ctrl_bit(input int aluop_w, input int ofs);
    return aluop_w + ofs;
  endfunction

endpackage

// File: rtl/id_ex_stage_reg_fwd_sel_calc.sv
// Priority comparator that picks the forwarding source for one operand.
// The candidate producers are the instruction that is about to enter EX/MEM
// and the instruction that is about to enter MEM/WB. The younger producer
// (EX side) wins. Register $0 never forwards.
module fwd_sel_calc
  import id_ex_stage_reg_pkg::*;
#(
  parameter int RADDR_W = 5
) (
  input  logic [RADDR_W-1:0] src_i,
  input  logic               ex_valid_i,
  input  logic               ex_regwrite_i,
  input  logic [RADDR_W-1:0] ex_rd_i,
  input  logic               mem_regwrite_i,
  input  logic [RADDR_W-1:0] mem_rd_i,
  output logic [1:0]         sel_o
);

  logic ex_hit;
  logic mem_hit;

  assign ex_hit  = ex_valid_i && ex_regwrite_i && (ex_rd_i != '0) && (ex_rd_i == src_i);
  assign mem_hit = mem_regwrite_i && (mem_rd_i != '0) && (mem_rd_i == src_i);

  // Youngest producer first, then the older one, otherwise the register file.
  always_comb begin
    sel_o = FWD_REG;
    if (ex_hit) begin
      sel_o = FWD_EXMEM;
    end else if (mem_hit) begin
      sel_o = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use bubble insertion and precomputed
// operand forward selects.
//
// Flow control:
//   - hold freezes the whole pipeline. Every register here keeps its value,
//     and stall_if_id stays low because upstream is already frozen.
//   - flush squashes the ID instruction by loading a bubble. It wins over
//     a load-use hazard and over hold.
//   - stall_if_id is high for exactly the cycle in which a load-use bubble
//     is written. IF/ID must then re-present the same instruction on the
//     next cycle.
//
// Forward selects are computed from the ID-side source addresses against
// the producers as they will be positioned one cycle later. They are
// registered together with the operands, so they line up with the operand
// data at the EX muxes.
module id_ex_stage_reg
  import id_ex_stage_reg_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5,
  parameter int ALUOP_W = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        id_valid,
  input  logic [DATA_W-1:0]           id_pc,
  input  logic [DATA_W-1:0]           id_rs_data,
  input  logic [DATA_W-1:0]           id_rt_data,
  input  logic [DATA_W-1:0]           id_imm,
  input  logic [RADDR_W-1:0]          id_rs,
  input  logic [RADDR_W-1:0]          id_rt,
  input  logic [RADDR_W-1:0]          id_rd,
  input  logic [ALUOP_W+CTRL_NBITS-1:0] id_ctrl,
  input  logic                        exmem_regwrite,
  input  logic [RADDR_W-1:0]          exmem_rd,
  input  logic                        hold,
  input  logic                        flush,
  output logic                        ex_valid,
  output logic [DATA_W-1:0]           ex_pc,
  output logic [DATA_W-1:0]           ex_rs_data,
  output logic [DATA_W-1:0]           ex_rt_data,
  output logic [DATA_W-1:0]           ex_imm,
  output logic [RADDR_W-1:0]          ex_rs,
  output logic [RADDR_W-1:0]          ex_rt,
  output logic [RADDR_W-1:0]          ex_rd,
  output logic [ALUOP_W+CTRL_NBITS-1:0] ex_ctrl,
  output logic [1:0]                  ex_fwd_a,
  output logic [1:0]                  ex_fwd_b,
  output logic                        stall_if_id
);

  localparam int CTRL_W       = ALUOP_W + CTRL_NBITS;
  localparam int B_REGWRITE   = ctrl_bit(ALUOP_W, CTRL_REGWRITE);
  localparam int B_MEMREAD    = ctrl_bit(ALUOP_W, CTRL_MEMREAD);
  localparam int B_MEMWRITE   = ctrl_bit(ALUOP_W, CTRL_MEMWRITE);
  localparam int B_ALUSRC     = ctrl_bit(ALUOP_W, CTRL_ALUSRC);

  // Pipeline register state.
  logic                 valid_q,   valid_d;
  logic [DATA_W-1:0]    pc_q,      pc_d;
  logic [DATA_W-1:0]    rs_data_q, rs_data_d;
  logic [DATA_W-1:0]    rt_data_q, rt_data_d;
  logic [DATA_W-1:0]    imm_q,     imm_d;
  logic [RADDR_W-1:0]   rs_q,      rs_d;
  logic [RADDR_W-1:0]   rt_q,      rt_d;
  logic [RADDR_W-1:0]   rd_q,      rd_d;
  logic [CTRL_W-1:0]    ctrl_q,    ctrl_d;
  logic [1:0]           fwd_a_q,   fwd_a_d;
  logic [1:0]           fwd_b_q,   fwd_b_d;

  // Hazard and forwarding terms.
  logic       id_reads_rt;
  logic       luse;
  logic [1:0] fwd_a_calc;
  logic [1:0] fwd_b_calc;

  // A store reads rt as data even though it uses the immediate for the ALU.
  assign id_reads_rt = !id_ctrl[B_ALUSRC] || id_ctrl[B_MEMWRITE];

  // The load in EX produces its data too late for the ID instruction's EX cycle.
  assign luse = valid_q && ctrl_q[B_MEMREAD] && (rd_q != '0) && id_valid &&
                ((rd_q == id_rs) || ((rd_q == id_rt) && id_reads_rt));

  assign stall_if_id = luse && !flush && !hold;

  fwd_sel_calc #(.RADDR_W(RADDR_W)) u_fwd_a (
    .src_i          (id_rs),
    .ex_valid_i     (valid_q),
    .ex_regwrite_i  (ctrl_q[B_REGWRITE]),
    .ex_rd_i        (rd_q),
    .mem_regwrite_i (exmem_regwrite),
    .mem_rd_i       (exmem_rd),
    .sel_o          (fwd_a_calc)
  );

  fwd_sel_calc #(.RADDR_W(RADDR_W)) u_fwd_b (
    .src_i          (id_rt),
    .ex_valid_i     (valid_q),
    .ex_regwrite_i  (ctrl_q[B_REGWRITE]),
    .ex_rd_i        (rd_q),
    .mem_regwrite_i (exmem_regwrite),
    .mem_rd_i       (exmem_rd),
    .sel_o          (fwd_b_calc)
  );

  // Next-state selection, in priority order: flush, hold, load-use bubble, capture.
  always_comb begin
    valid_d   = valid_q;
    pc_d      = pc_q;
    rs_data_d = rs_data_q;
    rt_data_d = rt_data_q;
    imm_d     = imm_q;
    rs_d      = rs_q;
    rt_d      = rt_q;
    rd_d      = rd_q;
    ctrl_d    = ctrl_q;
    fwd_a_d   = fwd_a_q;
    fwd_b_d   = fwd_b_q;
    if (flush || (!hold && luse)) begin
      // Bubble: nothing valid, no side effects, data fields cleared.
      valid_d   = 1'b0;
      pc_d      = '0;
      rs_data_d = '0;
      rt_data_d = '0;
      imm_d     = '0;
      rs_d      = '0;
      rt_d      = '0;
      rd_d      = '0;
      ctrl_d    = {CTRL_W{BUBBLE_CTRL}};
      fwd_a_d   = FWD_REG;
      fwd_b_d   = FWD_REG;
    end else if (!hold) begin
      valid_d   = id_valid;
      pc_d      = id_pc;
      rs_data_d = id_rs_data;
      rt_data_d = id_rt_data;
      imm_d     = id_imm;
      rs_d      = id_rs;
      rt_d      = id_rt;
      rd_d      = id_rd;
      ctrl_d    = id_ctrl;
      fwd_a_d   = fwd_a_calc;
      fwd_b_d   = fwd_b_calc;
    end
  end

  // State register with synchronous reset to an empty bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q   <= 1'b0;
      pc_q      <= '0;
      rs_data_q <= '0;
      rt_data_q <= '0;
      imm_q     <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      rd_q      <= '0;
      ctrl_q    <= '0;
      fwd_a_q   <= FWD_REG;
      fwd_b_q   <= FWD_REG;
    end else begin
      valid_q   <= valid_d;
      pc_q      <= pc_d;
      rs_data_q <= rs_data_d;
      rt_data_q <= rt_data_d;
      imm_q     <= imm_d;
      rs_q      <= rs_d;
      rt_q      <= rt_d;
      rd_q      <= rd_d;
      ctrl_q    <= ctrl_d;
      fwd_a_q   <= fwd_a_d;
      fwd_b_q   <= fwd_b_d;
    end
  end

  assign ex_valid   = valid_q;
  assign ex_pc      = pc_q;
  assign ex_rs_data = rs_data_q;
  assign ex_rt_data = rt_data_q;
  assign ex_imm     = imm_q;
  assign ex_rs      = rs_q;
  assign ex_rt      = rt_q;
  assign ex_rd      = rd_q;
  assign ex_ctrl    = ctrl_q;
  assign ex_fwd_a   = fwd_a_q;
  assign ex_fwd_b   = fwd_b_q;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Bench for id_ex_stage_reg: directed scenarios plus a randomized run
// against a behavioural model of the EX-stage register contents.
module tb_id_ex_stage_reg;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 9;
  localparam int VW = 1 + 4*DW + 3*AW + CW + 2 + 2;

  // Control bundle bits: {RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, ALUOp[3:0]}
  localparam logic [CW-1:0] C_ADD = 9'b1_0000_0010;
  localparam logic [CW-1:0] C_SUB = 9'b1_0000_0110;
  localparam logic [CW-1:0] C_LW  = 9'b1_1011_0000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic          id_valid;
  logic [DW-1:0] id_pc, id_rs_data, id_rt_data, id_imm;
  logic [AW-1:0] id_rs, id_rt, id_rd;
  logic [CW-1:0] id_ctrl;
  logic          exmem_regwrite;
  logic [AW-1:0] exmem_rd;
  logic          hold, flush;
  logic          ex_valid;
  logic [DW-1:0] ex_pc, ex_rs_data, ex_rt_data, ex_imm;
  logic [AW-1:0] ex_rs, ex_rt, ex_rd;
  logic [CW-1:0] ex_ctrl;
  logic [1:0]    ex_fwd_a, ex_fwd_b;
  logic          stall_if_id;

  id_ex_stage_reg #(.DATA_W(DW), .RADDR_W(AW), .ALUOP_W(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .id_valid       (id_valid),
    .id_pc          (id_pc),
    .id_rs_data     (id_rs_data),
    .id_rt_data     (id_rt_data),
    .id_imm         (id_imm),
    .id_rs          (id_rs),
    .id_rt          (id_rt),
    .id_rd          (id_rd),
    .id_ctrl        (id_ctrl),
    .exmem_regwrite (exmem_regwrite),
    .exmem_rd       (exmem_rd),
    .hold           (hold),
    .flush          (flush),
    .ex_valid       (ex_valid),
    .ex_pc          (ex_pc),
    .ex_rs_data     (ex_rs_data),
    .ex_rt_data     (ex_rt_data),
    .ex_imm         (ex_imm),
    .ex_rs          (ex_rs),
    .ex_rt          (ex_rt),
    .ex_rd          (ex_rd),
    .ex_ctrl        (ex_ctrl),
    .ex_fwd_a       (ex_fwd_a),
    .ex_fwd_b       (ex_fwd_b),
    .stall_if_id    (stall_if_id)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- behavioural model ----------------
  // The model holds what the EX stage should contain: one instruction record.
  logic          m_valid;
  logic [DW-1:0] m_pc, m_rs_data, m_rt_data, m_imm;
  logic [AW-1:0] m_rs, m_rt, m_rd;
  logic [CW-1:0] m_ctrl;
  logic [1:0]    m_fwd_a, m_fwd_b;

  function automatic logic [VW-1:0] dut_vec();
    return {ex_valid, ex_pc, ex_rs_data, ex_rt_data, ex_imm, ex_rs, ex_rt, ex_rd,
            ex_ctrl, ex_fwd_a, ex_fwd_b};
  endfunction

  function automatic logic [VW-1:0] model_vec();
    return {m_valid, m_pc, m_rs_data, m_rt_data, m_imm, m_rs, m_rt, m_rd,
            m_ctrl, m_fwd_a, m_fwd_b};
  endfunction

  // Which producer will hold src's newest value when the ID instruction reaches EX.
  function automatic logic [1:0] model_fwd(input logic [AW-1:0] src);
    if (src == 0) return 2'b00;
    if (m_valid && m_ctrl[8] && m_rd == src) return 2'b10;
    if (exmem_regwrite && exmem_rd == src) return 2'b01;
    return 2'b00;
  endfunction

  // The load in EX feeds a register the ID instruction actually reads.
  function automatic logic model_luse();
    logic reads_rt;
    reads_rt = !id_ctrl[4] || id_ctrl[6];
    return m_valid && m_ctrl[7] && (m_rd != 0) && id_valid &&
           ((m_rd == id_rs) || (m_rd == id_rt && reads_rt));
  endfunction

  function automatic logic model_stall();
    return model_luse() && !flush && !hold;
  endfunction

  // ---------------- driver tasks ----------------
  // Advance one clock, updating the model from the inputs applied before the edge.
  task automatic tick();
    logic bubble, keep;
    logic [1:0] fa, fb;
    bubble = reset || flush || (!hold && model_luse());
    keep   = !bubble && hold;
    fa = model_fwd(id_rs);
    fb = model_fwd(id_rt);
    @(posedge clk);
    #1;
    if (bubble) begin
      {m_valid, m_pc, m_rs_data, m_rt_data, m_imm, m_rs, m_rt, m_rd, m_ctrl, m_fwd_a, m_fwd_b} = '0;
    end else if (!keep) begin
      m_valid = id_valid; m_pc = id_pc; m_rs_data = id_rs_data; m_rt_data = id_rt_data;
      m_imm = id_imm; m_rs = id_rs; m_rt = id_rt; m_rd = id_rd; m_ctrl = id_ctrl;
      m_fwd_a = fa; m_fwd_b = fb;
    end
  endtask

  task automatic idle_inputs();
    id_valid = 0; id_pc = '0; id_rs_data = '0; id_rt_data = '0; id_imm = '0;
    id_rs = '0; id_rt = '0; id_rd = '0; id_ctrl = '0;
    exmem_regwrite = 0; exmem_rd = '0; hold = 0; flush = 0;
  endtask

  task automatic set_id(input logic v, input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                        input logic [AW-1:0] rd, input logic [CW-1:0] ctrl);
    id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd; id_ctrl = ctrl;
    id_pc = $urandom; id_rs_data = $urandom; id_rt_data = $urandom; id_imm = $urandom;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    tick();
    tick();
    reset = 0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    n_tests++;
    if (dut_vec() !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got %h want 0", dut_vec());
    end
    #1;
    n_tests++;
    if (stall_if_id !== 1'b0) begin
      n_fail++; $display("FAIL reset_stall: got %b want 0", stall_if_id);
    end
  endtask

  task automatic test_ex_fwd();
    do_reset();
    set_id(1, 5'd1, 5'd2, 5'd3, C_ADD);
    tick();
    set_id(1, 5'd3, 5'd4, 5'd9, C_SUB);
    tick();
    n_tests++;
    if (ex_fwd_a !== 2'b10 || ex_fwd_b !== 2'b00) begin
      n_fail++; $display("FAIL ex_fwd: got a=%b b=%b want a=10 b=00", ex_fwd_a, ex_fwd_b);
    end
    n_tests++;
    if (dut_vec() !== model_vec()) begin
      n_fail++; $display("FAIL ex_fwd_capture: got %h want %h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_double_hazard();
    do_reset();
    set_id(1, 5'd1, 5'd2, 5'd5, C_ADD);
    tick();
    set_id(1, 5'd5, 5'd5, 5'd6, C_ADD);
    exmem_regwrite = 1; exmem_rd = 5'd5;
    tick();
    n_tests++;
    if (ex_fwd_a !== 2'b10 || ex_fwd_b !== 2'b10) begin
      n_fail++; $display("FAIL double_hazard: got a=%b b=%b want a=10 b=10", ex_fwd_a, ex_fwd_b);
    end
  endtask

  task automatic test_load_use();
    int stalls;
    stalls = 0;
    do_reset();
    set_id(1, 5'd1, 5'd0, 5'd7, C_LW);
    tick();
    set_id(1, 5'd7, 5'd8, 5'd9, C_ADD);
    #1;
    if (stall_if_id === 1'b1) stalls++;
    n_tests++;
    if (stall_if_id !== 1'b1) begin
      n_fail++; $display("FAIL luse_stall: got %b want 1", stall_if_id);
    end
    tick();
    n_tests++;
    if (ex_valid !== 1'b0 || ex_ctrl !== '0) begin
      n_fail++; $display("FAIL luse_bubble: got valid=%b ctrl=%h want 0/0", ex_valid, ex_ctrl);
    end
    exmem_regwrite = 1; exmem_rd = 5'd7;
    #1;
    if (stall_if_id === 1'b1) stalls++;
    tick();
    n_tests++;
    if (stalls != 1) begin
      n_fail++; $display("FAIL luse_stall_count: got %0d want 1", stalls);
    end
    n_tests++;
    if (ex_valid !== 1'b1 || ex_fwd_a !== 2'b01 || ex_rd !== 5'd9) begin
      n_fail++; $display("FAIL luse_reload: got valid=%b fwd_a=%b rd=%0d want 1/01/9",
                         ex_valid, ex_fwd_a, ex_rd);
    end
  endtask

  task automatic test_flush_vs_luse();
    do_reset();
    set_id(1, 5'd1, 5'd0, 5'd7, C_LW);
    tick();
    set_id(1, 5'd7, 5'd8, 5'd9, C_ADD);
    flush = 1;
    #1;
    n_tests++;
    if (stall_if_id !== 1'b0) begin
      n_fail++; $display("FAIL flush_stall: got %b want 0", stall_if_id);
    end
    tick();
    n_tests++;
    if (ex_valid !== 1'b0 || ex_ctrl !== '0 || ex_fwd_a !== 2'b00) begin
      n_fail++; $display("FAIL flush_bubble: got valid=%b ctrl=%h fwd_a=%b want 0/0/00",
                         ex_valid, ex_ctrl, ex_fwd_a);
    end
    flush = 0;
    set_id(1, 5'd7, 5'd8, 5'd10, C_ADD);
    #1;
    n_tests++;
    if (stall_if_id !== 1'b0) begin
      n_fail++; $display("FAIL flush_no_second_stall: got %b want 0", stall_if_id);
    end
    tick();
    n_tests++;
    if (ex_valid !== 1'b1 || ex_rd !== 5'd10) begin
      n_fail++; $display("FAIL flush_next_load: got valid=%b rd=%0d want 1/10", ex_valid, ex_rd);
    end
  endtask

  task automatic test_hold_zero();
    logic [VW-1:0] saved;
    do_reset();
    set_id(1, 5'd2, 5'd3, 5'd4, C_LW);
    tick();
    saved = model_vec();
    hold = 1;
    for (int i = 0; i < 3; i++) begin
      set_id(1, 5'd4, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 9'($urandom));
      #1;
      n_tests++;
      if (stall_if_id !== 1'b0) begin
        n_fail++; $display("FAIL hold_stall[%0d]: got %b want 0", i, stall_if_id);
      end
      tick();
      n_tests++;
      if (dut_vec() !== saved) begin
        n_fail++; $display("FAIL hold_keep[%0d]: got %h want %h", i, dut_vec(), saved);
      end
    end
    hold = 0;
    set_id(1, 5'd1, 5'd2, 5'd0, C_ADD);
    tick();
    set_id(1, 5'd0, 5'd3, 5'd5, C_ADD);
    exmem_regwrite = 1; exmem_rd = 5'd0;
    tick();
    n_tests++;
    if (ex_valid !== 1'b1 || ex_fwd_a !== 2'b00) begin
      n_fail++; $display("FAIL zero_no_fwd: got valid=%b fwd_a=%b want 1/00", ex_valid, ex_fwd_a);
    end
  endtask

  task automatic test_random();
    logic exp_stall;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      id_valid = ($urandom_range(0, 7) != 0);
      id_pc = $urandom; id_rs_data = $urandom; id_rt_data = $urandom; id_imm = $urandom;
      id_rs = 5'($urandom_range(0, 7));
      id_rt = 5'($urandom_range(0, 7));
      id_rd = 5'($urandom_range(0, 7));
      id_ctrl = 9'($urandom);
      exmem_regwrite = $urandom_range(0, 1);
      exmem_rd = 5'($urandom_range(0, 7));
      flush = ($urandom_range(0, 7) == 0);
      hold  = ($urandom_range(0, 5) == 0);
      reset = ($urandom_range(0, 63) == 0);
      #1;
      exp_stall = model_stall();
      n_tests++;
      if (stall_if_id !== exp_stall) begin
        n_fail++; $display("FAIL rand_stall[%0d]: got %b want %b", i, stall_if_id, exp_stall);
      end
      tick();
      n_tests++;
      if (dut_vec() !== model_vec()) begin
        n_fail++; $display("FAIL rand_regs[%0d]: got %h want %h", i, dut_vec(), model_vec());
      end
    end
    reset = 0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset = 1;
    idle_inputs();
    {m_valid, m_pc, m_rs_data, m_rt_data, m_imm, m_rs, m_rt, m_rd, m_ctrl, m_fwd_a, m_fwd_b} = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_ex_fwd();
    test_double_hazard();
    test_load_use();
    test_flush_vs_luse();
    test_hold_zero();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
